// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register write arbiter: requester count, data
// width, FSM state encoding, reset values and a one-hot grant helper.
// Ports: none (package only).
package reg_arb_pkg;

    localparam int N_REQ = 4;
    localparam int W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        ACK   = 2'b10
    } state_t;

    // last starts at 3 so requester 0 wins the first arbitration after reset
    localparam logic [1:0]   LAST_RESET = 2'd3;
    localparam logic [W-1:0] Q_RESET    = '0;

    function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick4.sv
// Combinational round-robin picker for four requesters.
// Ports:
//   req   [3:0]  request vector
//   last  [1:0]  index of the previously served requester
//   valid        at least one request present
//   idx   [1:0]  first set bit searching upward from last+1, wrapping
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] cand;
    logic       found;

    // Walk last+1, last+2, last+3, last (2-bit wrap) and keep the first hit,
    // so the most recently served requester has the lowest priority.
    always_comb begin
        valid = |req;
        idx   = last;
        cand  = last;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter letting four requesters write one shared register.
// Each transaction takes IDLE (arbitrate) -> WRITE (load Q) -> ACK (pulse ack).
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   req   [N_REQ-1:0]   level write requests
//   data0..data3 [W-1:0] per-requester write data
//   ack   [N_REQ-1:0]   one-hot write-done pulse to the granted requester
//   Q     [W-1:0]       shared register contents
//   owner [1:0]         current or last granted requester
//   busy                FSM not in IDLE
//   wr_count [7:0]      completed writes, wrapping
module reg_write_arbiter #(
    parameter int N_REQ = reg_arb_pkg::N_REQ,
    parameter int W     = reg_arb_pkg::W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] req,
    input  logic [W-1:0]     data0,
    input  logic [W-1:0]     data1,
    input  logic [W-1:0]     data2,
    input  logic [W-1:0]     data3,
    output logic [N_REQ-1:0] ack,
    output logic [W-1:0]     Q,
    output logic [1:0]       owner,
    output logic             busy,
    output logic [7:0]       wr_count
);

    import reg_arb_pkg::*;

    state_t       state;
    logic [1:0]   last;
    logic         pick_valid;
    logic [1:0]   pick_idx;
    logic         wr_en;
    logic [W-1:0] wr_d;

    rr_pick4 u_pick (
        .req   (req),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Write port of the shared register: only the granted requester's data
    // is selected, and only while in WRITE.
    always_comb begin
        wr_en = (state == WRITE);
        case (owner)
            2'd0:    wr_d = data0;
            2'd1:    wr_d = data1;
            2'd2:    wr_d = data2;
            default: wr_d = data3;
        endcase
    end

    // Shared register; reset clears it even mid-transaction so an aborted
    // write never leaves data behind.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Q <= Q_RESET;
        end else if (wr_en) begin
            Q <= wr_d;
        end
    end

    // Transaction FSM. The grant is held in owner for the whole transaction,
    // so dropping req after the grant cannot cancel the write or the ack.
    // last only advances in ACK, which makes a still-asserted req of the
    // just-served requester rank lowest in the following IDLE cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            ack      <= '0;
            owner    <= 2'd0;
            last     <= LAST_RESET;
            wr_count <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= '0;
                    if (pick_valid) begin
                        owner <= pick_idx;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    ack   <= onehot4(owner);
                    state <= ACK;
                end
                ACK: begin
                    ack      <= '0;
                    last     <= owner;
                    wr_count <= wr_count + 8'd1;
                    state    <= IDLE;
                end
                default: begin
                    ack   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter.
module tb_reg_write_arbiter;

    logic       CLK;
    logic       RST;
    logic [3:0] req;
    logic [7:0] data0, data1, data2, data3;
    logic [3:0] ack;
    logic [7:0] Q;
    logic [1:0] owner;
    logic       busy;
    logic [7:0] wr_count;

    int checks = 0;
    int errors = 0;

    reg_write_arbiter dut (
        .CLK      (CLK),
        .RST      (RST),
        .req      (req),
        .data0    (data0),
        .data1    (data1),
        .data2    (data2),
        .data3    (data3),
        .ack      (ack),
        .Q        (Q),
        .owner    (owner),
        .busy     (busy),
        .wr_count (wr_count)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] expQ, input logic [3:0] expAck,
                               input logic [1:0] expOwner, input logic expBusy, input logic [7:0] expCount);
        checkVal({tag, ".Q"},        Q,               expQ);
        checkVal({tag, ".ack"},      {4'b0, ack},     {4'b0, expAck});
        checkVal({tag, ".owner"},    {6'b0, owner},   {6'b0, expOwner});
        checkVal({tag, ".busy"},     {7'b0, busy},    {7'b0, expBusy});
        checkVal({tag, ".wr_count"}, wr_count,        expCount);
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [7:0] d0, input logic [7:0] d1,
                                 input logic [7:0] d2, input logic [7:0] d3);
        req   = r;
        data0 = d0;
        data1 = d1;
        data2 = d2;
        data3 = d3;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Mid-cycle reset pulse (starting 1 ns after an edge, ending before the next).
    task automatic pulseReset();
        RST = 1'b1;
        #3;
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        #3;
        checkOutput("reset", 8'h00, 4'b0000, 2'd0, 1'b0, 8'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // Single write from requester 0
        applyStimulus(4'b0001, 8'hA5, 8'h00, 8'h00, 8'h00);
        tick();
        checkOutput("single.write", 8'h00, 4'b0000, 2'd0, 1'b1, 8'd0);
        req = 4'b0000;
        tick();
        checkOutput("single.ack", 8'hA5, 4'b0001, 2'd0, 1'b1, 8'd0);
        tick();
        checkOutput("single.idle", 8'hA5, 4'b0000, 2'd0, 1'b0, 8'd1);

        // All four requesting continuously: rotation 0,1,2,3,0
        pulseReset();
        applyStimulus(4'b1111, 8'h10, 8'h11, 8'h12, 8'h13);
        for (int i = 0; i < 5; i++) begin
            logic [1:0] g;
            g = 2'(i % 4);
            tick();
            checkVal("rot.owner", {6'b0, owner}, {6'b0, g});
            checkVal("rot.ack_write", {4'b0, ack}, 8'h00);
            tick();
            checkVal("rot.Q", Q, 8'h10 + 8'(g));
            checkVal("rot.ack", {4'b0, ack}, {4'b0, 4'b0001 << g});
            tick();
            checkVal("rot.busy", {7'b0, busy}, 8'h00);
            checkVal("rot.count", wr_count, 8'(i + 1));
        end

        // Requester 2 granted; 0 and 1 arrive during WRITE and must wait
        applyStimulus(4'b0100, 8'hA0, 8'hB1, 8'h22, 8'h00);
        tick();
        checkOutput("late.grant2", 8'h10, 4'b0000, 2'd2, 1'b1, 8'd5);
        req = 4'b0011;
        tick();
        checkOutput("late.ack2", 8'h22, 4'b0100, 2'd2, 1'b1, 8'd5);
        tick();
        checkOutput("late.idle2", 8'h22, 4'b0000, 2'd2, 1'b0, 8'd6);
        tick();
        checkOutput("late.grant0", 8'h22, 4'b0000, 2'd0, 1'b1, 8'd6);
        tick();
        checkOutput("late.ack0", 8'hA0, 4'b0001, 2'd0, 1'b1, 8'd6);
        tick();
        checkOutput("late.idle0", 8'hA0, 4'b0000, 2'd0, 1'b0, 8'd7);
        tick();
        checkOutput("late.grant1", 8'hA0, 4'b0000, 2'd1, 1'b1, 8'd7);
        tick();
        checkOutput("late.ack1", 8'hB1, 4'b0010, 2'd1, 1'b1, 8'd7);
        req = 4'b0000;
        tick();
        checkOutput("late.idle1", 8'hB1, 4'b0000, 2'd1, 1'b0, 8'd8);
        tick();
        checkOutput("late.hold", 8'hB1, 4'b0000, 2'd1, 1'b0, 8'd8);

        // Reset during WRITE aborts the transaction
        applyStimulus(4'b0001, 8'h3C, 8'h00, 8'h00, 8'h00);
        tick();
        checkOutput("abort.write", 8'hB1, 4'b0000, 2'd0, 1'b1, 8'd8);
        req = 4'b0000;
        #2;
        RST = 1'b1;
        #1;
        checkOutput("abort.async", 8'h00, 4'b0000, 2'd0, 1'b0, 8'd0);
        RST = 1'b0;
        tick();
        checkOutput("abort.after1", 8'h00, 4'b0000, 2'd0, 1'b0, 8'd0);
        tick();
        checkOutput("abort.after2", 8'h00, 4'b0000, 2'd0, 1'b0, 8'd0);

        // Requester 3 drops req in WRITE: write and ack still happen, no regrant
        applyStimulus(4'b1000, 8'h00, 8'h00, 8'h00, 8'h77);
        tick();
        checkOutput("drop.write", 8'h00, 4'b0000, 2'd3, 1'b1, 8'd0);
        req = 4'b0000;
        tick();
        checkOutput("drop.ack", 8'h77, 4'b1000, 2'd3, 1'b1, 8'd0);
        tick();
        checkOutput("drop.idle", 8'h77, 4'b0000, 2'd3, 1'b0, 8'd1);
        tick();
        checkOutput("drop.noregrant", 8'h77, 4'b0000, 2'd3, 1'b0, 8'd1);

        // 256 single writes: wr_count wraps to zero
        pulseReset();
        for (int i = 0; i < 256; i++) begin
            applyStimulus(4'b0001, 8'(i), 8'h00, 8'h00, 8'h00);
            tick();
            req = 4'b0000;
            tick();
            tick();
            if (i == 254) checkVal("wrap.count255", wr_count, 8'hFF);
        end
        checkOutput("wrap.final", 8'hFF, 4'b0000, 2'd0, 1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the register; fixed at 4 in this revision.
REQ-002 Parameter W, default 8, data width of the shared register.
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 req  input  4  per-requester write request, level, bit i = requester i.
REQ-006 data0..data3  input  8 each  write data of requester i, held stable while req[i]=1.
REQ-007 ack  output  4  one-hot, one-cycle write-done pulse to the granted requester.
REQ-008 Q  output  8  shared register contents.
REQ-009 owner  output  2  index of the current or last granted requester.
REQ-010 busy  output  1  high when the state is not IDLE.
REQ-011 wr_count  output  8  count of completed writes, wraps 255->0.

Function
REQ-012 The FSM SHALL have three states: IDLE, WRITE, ACK.
REQ-013 IDLE->WRITE when req!=0: latch grant g = first set bit of req searching (last+1) mod 4 upward, wrapping; set owner=g.
REQ-014 IDLE SHALL stay IDLE when req==0; Q, owner and wr_count hold.
REQ-015 WRITE: internal enable=1 and D=data_g for exactly one cycle; Q<=data_g at the end of the cycle; next state ACK.
REQ-016 ACK: ack[g]=1 for exactly one cycle; last<=g; wr_count<=wr_count+1 (mod 256); next state IDLE.
REQ-017 Latency: req sampled at edge n -> Q and ack[g] visible in the cycle after edge n+1 -> IDLE after edge n+2; peak throughput one write per 3 cycles.
REQ-018 Once granted, the transaction SHALL complete; dropping req[g] in WRITE or ACK does not cancel the write or the ack.
REQ-019 Requests arriving during WRITE/ACK SHALL wait; arbitration occurs only in IDLE.
REQ-020 A req[g] still high in the IDLE cycle after its ack SHALL count as a new request at lowest rotating priority.
REQ-021 Data of non-granted requesters SHALL never reach Q; ack bits other than g SHALL stay 0.
REQ-022 With all four requesting continuously, grants SHALL rotate 0,1,2,3,0,... with no starvation.

Reset
REQ-023 RST=1 SHALL immediately, without a clock: state=IDLE, Q=0x00, ack=0, owner=0, busy=0, wr_count=0, last=3 (requester 0 has first priority).
REQ-024 RST asserted during WRITE or ACK SHALL abort the transaction: no ack issued and Q=0x00.
REQ-025 After RST deasserts, the first arbitration SHALL occur at the first rising edge with RST=0.

Structure
REQ-026 Package reg_arb_pkg SHALL hold N_REQ, W, the state encoding (IDLE=2'b00, WRITE=2'b01, ACK=2'b10) and the reset values of last and Q.
REQ-027 The round-robin search SHALL be the combinational sub-module rr_pick4 (inputs req, last; outputs valid, idx).
REQ-028 The shared register SHALL be implemented inside the block with asynchronous reset; an unused 2'b11 state code SHALL return to IDLE.

Verification
REQ-029 After reset, pulse req=0001, data0=0xA5 -> Q=0xA5 two edges later, ack=0001 for one cycle, wr_count=1, owner=0.
REQ-030 Hold req=1111 with data_i=0x10+i -> grants 0,1,2,3,0, Q sequence 0x10,0x11,0x12,0x13,0x10, ack every 3 cycles.
REQ-031 req=0100 granted, then req=0011 raised in WRITE -> ack=0100 first, then requester 0 granted, then requester 1.
REQ-032 Assert RST for a partial cycle during WRITE with data=0x3C -> Q=0x00, ack never pulses, busy=0 asynchronously.
REQ-033 Perform 256 single writes -> wr_count wraps to 0x00; Q equals the last data written.
REQ-034 Drop req[g] in the WRITE cycle -> Q updates and ack[g] pulses anyway; no second grant to g.
